// File: rtl/configurable_down_counter.sv
// ---------------------------------------------------------------------------
// configurable_down_counter
//   Loadable down-counter / timer. A load captures load_value into both the
//   count and the reload register and starts counting toward zero. Reaching
//   zero raises a one-cycle terminal-count pulse. With auto_reload set, the
//   count then restarts from the reload register, which gives a periodic tick.
//
//   Optional feature macro: DOWN_COUNTER_PRESCALE_EN
//     defined   -> one decrement step every PRESCALE clocks while in RUN
//     undefined -> one decrement step every clock while in RUN
//
//   State table
//     state    | meaning
//     S_IDLE   | stopped, count holds (normally 0), tc low
//     S_RUN    | counting down (frozen while hold=1)
//     S_EXPIRE | one cycle after terminal count; reload or stop
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   load         in   capture load_value into count and reload register
//   hold         in   freeze count/prescaler while in RUN
//   auto_reload  in   sampled in EXPIRE: restart from the reload register
//   load_value   in   [WIDTH-1:0] value captured on load
//   count        out  [WIDTH-1:0] current count (registered)
//   tc           out  terminal-count pulse (registered, 1 cycle)
//   busy         out  high in RUN or EXPIRE
// ---------------------------------------------------------------------------
module configurable_down_counter #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             hold,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_EXPIRE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;
   logic             tc_d;
   logic             step;
   logic             load_zero;
   logic             reload_ok;

   assign load_zero = (load_value == '0);
   assign reload_ok = auto_reload && (reload_q != '0);

`ifdef DOWN_COUNTER_PRESCALE_EN
   // PRESCALE of 1 still needs a 1-bit register so the compare is legal.
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;

   assign step = (presc_q == PRE_LAST);

   // Runs only in RUN; anything else (load, IDLE, EXPIRE) parks it at zero so
   // every fresh count gets a full first step.
   always_comb begin
      presc_d = presc_q;
      if (load || (state_q != S_RUN)) begin
         presc_d = '0;
      end else if (!hold) begin
         presc_d = step ? '0 : (presc_q + PRE_ONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign step = 1'b1;
`endif

   // State register together with the registered outputs it steers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count    <= '0;
         reload_q <= '0;
         tc       <= 1'b0;
      end else begin
         state_q  <= state_d;
         count    <= count_d;
         reload_q <= reload_d;
         tc       <= tc_d;
      end
   end

   // Next-state logic. Load overrides everything, including the EXPIRE cycle.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_zero ? S_IDLE : S_RUN;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
               // count==0 in RUN should never happen; drop out rather than wrap.
               if (count == '0) begin
                  state_d = S_IDLE;
               end else if (!hold && step && (count == CNT_ONE)) begin
                  state_d = S_EXPIRE;
               end
            end
            S_EXPIRE: state_d = reload_ok ? S_RUN : S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values. tc defaults low so it can only ever be a
   // single-cycle pulse.
   always_comb begin
      count_d  = count;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load) begin
         count_d  = load_value;
         reload_d = load_value;
      end else begin
         unique case (state_q)
            S_RUN: begin
               if ((count != '0) && !hold && step) begin
                  count_d = count - CNT_ONE;
                  tc_d    = (count == CNT_ONE);
               end
            end
            S_EXPIRE: begin
               if (reload_ok) begin
                  count_d = reload_q;
               end
            end
            default: begin
               count_d = count;
            end
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_configurable_down_counter.sv
`timescale 1ns/1ps
module tb_configurable_down_counter;

   localparam int WIDTH    = 4;
   localparam int PRESCALE = 4;
`ifdef DOWN_COUNTER_PRESCALE_EN
   localparam int STEP = PRESCALE;
`else
   localparam int STEP = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load = 1'b0;
   logic             hold = 1'b0;
   logic             auto_reload = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   configurable_down_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .hold        (hold),
      .auto_reload (auto_reload),
      .load_value  (load_value),
      .count       (count),
      .tc          (tc),
      .busy        (busy)
   );

   // ---------------- behavioural reference ----------------
   // mode: 0 = stopped, 1 = counting, 2 = the single cycle after reaching 0
   int m_count;
   int m_reload;
   int m_mode;
   int m_tick;
   bit m_tc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_count  <= 0;
         m_reload <= 0;
         m_mode   <= 0;
         m_tick   <= 0;
         m_tc     <= 0;
      end else if (load) begin
         m_count  <= int'(load_value);
         m_reload <= int'(load_value);
         m_mode   <= (load_value != 0) ? 1 : 0;
         m_tick   <= 0;
         m_tc     <= 0;
      end else if (m_mode == 2) begin
         m_tc   <= 0;
         m_tick <= 0;
         if (auto_reload && m_reload != 0) begin
            m_count <= m_reload;
            m_mode  <= 1;
         end else begin
            m_mode <= 0;
         end
      end else if (m_mode == 1) begin
         m_tc <= 0;
         if (m_count == 0) begin
            m_mode <= 0;
         end else if (!hold) begin
            if (m_tick + 1 == STEP) begin
               m_tick  <= 0;
               m_count <= m_count - 1;
               if (m_count == 1) begin
                  m_tc   <= 1;
                  m_mode <= 2;
               end
            end else begin
               m_tick <= m_tick + 1;
            end
         end
      end else begin
         m_tc <= 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      check("model_count", 32'(count), 32'(m_count));
      check("model_tc",    32'(tc),    32'(m_tc));
      check("model_busy",  32'(busy),  32'(m_mode != 0));
   end

   // advance to 2ns after the next rising edge; inputs change only here
   task automatic step_cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_load(input int v);
      load       = 1'b1;
      load_value = WIDTH'(v);
      step_cyc();
      load       = 1'b0;
   endtask

   task automatic expect_out(input string name, input int c, input bit t, input bit b);
      check({name, "_count"}, 32'(count), 32'(c));
      check({name, "_tc"},    32'(tc),    32'(t));
      check({name, "_busy"},  32'(busy),  32'(b));
   endtask

   initial begin
      int seq4 [9];
      seq4 = '{3, 2, 1, 0, 3, 2, 1, 0, 3};

      #3;
      expect_out("reset", 0, 0, 0);
      #4 rst_n = 1'b1;
      step_cyc();

      // async reset mid-count, asserted between edges
      do_load(9);
      step_cyc();
      #1 rst_n = 1'b0;
      #1 expect_out("async_rst", 0, 0, 0);
      rst_n = 1'b1;
      step_cyc();
      expect_out("after_rst", 0, 0, 0);

`ifndef DOWN_COUNTER_PRESCALE_EN
      // plain countdown from 5
      auto_reload = 1'b0;
      do_load(5);
      expect_out("cnt5_load", 5, 0, 1);
      for (int v = 4; v >= 0; v--) begin
         step_cyc();
         expect_out("cnt5_run", v, (v == 0), 1);
      end
      step_cyc();
      expect_out("cnt5_idle", 0, 0, 0);

      // hold for 3 cycles at 7
      do_load(9);
      step_cyc();
      step_cyc();
      expect_out("hold_pre", 7, 0, 1);
      hold = 1'b1;
      repeat (3) begin
         step_cyc();
         expect_out("hold_frz", 7, 0, 1);
      end
      hold = 1'b0;
      step_cyc();
      expect_out("hold_6", 6, 0, 1);
      step_cyc();
      expect_out("hold_5", 5, 0, 1);

      // auto-reload from 3: tc every 4 clocks
      auto_reload = 1'b1;
      do_load(3);
      expect_out("ar_load", 3, 0, 1);
      for (int i = 1; i < 9; i++) begin
         step_cyc();
         expect_out("ar_seq", seq4[i], (seq4[i] == 0) && (i != 0), 1);
      end
      auto_reload = 1'b0;

      // load of zero stops with no tc
      do_load(0);
      expect_out("load0", 0, 0, 0);
      step_cyc();
      expect_out("load0_hold", 0, 0, 0);

      // load in the tc cycle wins
      do_load(3);
      repeat (3) step_cyc();
      expect_out("tc_cycle", 0, 1, 1);
      do_load(2);
      expect_out("load_in_tc", 2, 0, 1);
      step_cyc();
      expect_out("load_in_tc_next", 1, 0, 1);
`else
      // prescaled countdown from 2
      auto_reload = 1'b0;
      do_load(2);
      expect_out("ps_2", 2, 0, 1);
      repeat (3) begin
         step_cyc();
         expect_out("ps_2", 2, 0, 1);
      end
      repeat (4) begin
         step_cyc();
         expect_out("ps_1", 1, 0, 1);
      end
      step_cyc();
      expect_out("ps_0", 0, 1, 1);
      step_cyc();
      expect_out("ps_idle", 0, 0, 0);
`endif

      // randomized traffic, checked by the per-cycle compare
      for (int cyc = 0; cyc < 3000; cyc++) begin
         load        = ($urandom_range(0, 11) == 0);
         load_value  = WIDTH'($urandom);
         hold        = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) auto_reload = ~auto_reload;
         if ($urandom_range(0, 399) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         step_cyc();
      end
      load = 1'b0;
      hold = 1'b0;
      step_cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
